// File: rtl/reg_file_sb.sv
// Register file: two combinational read ports, one write port, write-through bypass, busy scoreboard.
// Latency: reads are zero-cycle; writes, reservations and busy_count update on the rising edge.
// Backpressure: none; every strobe is accepted on the cycle it is presented.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_busy_1,
  output logic              read_busy_2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_count
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  // An address is live if it is implemented and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic wr_ok, rsv_ok, same_addr, cnt_inc, cnt_dec;

  always_comb begin
    wr_ok     = write_en && addr_ok(write_addr);
    rsv_ok    = rsv_en && addr_ok(rsv_addr);
    same_addr = wr_ok && rsv_ok && (write_addr == rsv_addr);
    // A write to a register reserved in the same cycle leaves it busy, so it never decrements.
    cnt_inc   = rsv_ok && !busy[rsv_addr];
    cnt_dec   = wr_ok && busy[write_addr] && !same_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_ok) begin
        regs[write_addr] <= write_data;
        busy[write_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[rsv_addr] <= 1'b1;
      end
      case ({cnt_inc, cnt_dec})
        2'b10:   busy_count <= busy_count + (ADDR_W+1)'(1);
        2'b01:   busy_count <= busy_count - (ADDR_W+1)'(1);
        default: busy_count <= busy_count;
      endcase
    end
  end

  always_comb begin
    read_data_1 = '0;
    read_busy_1 = 1'b0;
    if ((BYPASS != 0) && wr_ok && (write_addr == read_addr_1)) begin
      read_data_1 = write_data;
    end else if (addr_ok(read_addr_1)) begin
      read_data_1 = regs[read_addr_1];
      read_busy_1 = busy[read_addr_1];
    end
  end

  always_comb begin
    read_data_2 = '0;
    read_busy_2 = 1'b0;
    if ((BYPASS != 0) && wr_ok && (write_addr == read_addr_2)) begin
      read_data_2 = write_data;
    end else if (addr_ok(read_addr_2)) begin
      read_data_2 = regs[read_addr_2];
      read_busy_2 = busy[read_addr_2];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: driver pushes model predictions, a negedge monitor pops and compares.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_addr_1, read_addr_2, write_addr, rsv_addr;
  logic [31:0] read_data_1, read_data_2, write_data;
  logic        read_busy_1, read_busy_2, write_en, rsv_en;
  logic [5:0]  busy_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .read_busy_1(read_busy_1), .read_busy_2(read_busy_2),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_count(busy_count)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural register contents and the set of reserved registers.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic int m_count();
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(m_busy[i]);
    return s;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic void m_read(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, output logic [31:0] d, output logic b);
    if (a == 0) begin
      d = '0; b = 1'b0;
    end else if (we && wa == a) begin
      d = wd; b = 1'b0;
    end else begin
      d = m_regs[a]; b = m_busy[a];
    end
  endfunction

  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re, input logic [4:0] ra, input logic [4:0] a1, input logic [4:0] a2,
                      input string tag);
    exp_t e;
    rst = r; write_en = we; write_addr = wa; write_data = wd;
    rsv_en = re; rsv_addr = ra; read_addr_1 = a1; read_addr_2 = a2;
    if (r) m_clear();
    m_read(a1, we && !r, wa, wd, e.d1, e.b1);
    m_read(a2, we && !r, wa, wd, e.d2, e.b2);
    e.cnt = 6'(m_count());
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      m_clear();
    end else begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (re && ra != 0) m_busy[ra] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, " read_data_1"}, read_data_1, e.d1);
      chk({e.tag, " read_data_2"}, read_data_2, e.d2);
      chk({e.tag, " read_busy_1"}, 32'(read_busy_1), 32'(e.b1));
      chk({e.tag, " read_busy_2"}, 32'(read_busy_2), 32'(e.b2));
      chk({e.tag, " busy_count"}, 32'(busy_count), 32'(e.cnt));
    end
  end

  initial begin
    logic prev_rst;
    logic r, we, re;
    logic [4:0] wa, ra, a1, a2;
    rst = 1'b1; write_en = 0; write_addr = 0; write_data = 0;
    rsv_en = 0; rsv_addr = 0; read_addr_1 = 0; read_addr_2 = 0;
    m_clear();
    @(posedge clk);
    #1;

    // Reset state across every address.
    for (int i = 0; i < 32; i++) step(1'b1, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), "reset_scan");
    step(0, 0, 0, 0, 0, 0, 0, 0, "release");

    // Bypass then stored readback.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, "bypass_r5");
    step(0, 0, 0, 0, 0, 0, 5, 5, "readback_r5");

    // Register 0 is immune to writes and reservations.
    step(0, 1, 0, 32'h12345678, 0, 0, 0, 5, "write_r0");
    step(0, 0, 0, 0, 1, 0, 0, 0, "rsv_r0");
    step(0, 0, 0, 0, 0, 0, 0, 0, "after_r0");

    // Two reservations, then a writeback releases one.
    step(0, 0, 0, 0, 1, 7, 7, 9, "rsv_r7");
    step(0, 0, 0, 0, 1, 9, 7, 9, "rsv_r9");
    step(0, 1, 7, 32'h55, 0, 0, 7, 9, "write_r7");
    step(0, 0, 0, 0, 1, 9, 7, 9, "rersv_r9");
    step(0, 0, 0, 0, 0, 0, 7, 9, "after_r7");

    // Same-cycle reserve and write: data lands, reserve wins.
    step(0, 1, 3, 32'hAA, 1, 3, 3, 0, "rsv_wr_r3");
    step(0, 0, 0, 0, 0, 0, 3, 9, "after_r3");

    // Reset between edges discards everything.
    step(0, 0, 0, 0, 1, 4, 4, 6, "rsv_r4");
    step(0, 1, 6, 32'h77, 1, 5, 4, 6, "write_r6");
    step(1, 0, 0, 0, 1, 8, 4, 6, "mid_reset");
    step(0, 0, 0, 0, 0, 0, 4, 6, "post_reset");
    step(0, 1, 6, 32'h1, 0, 0, 4, 0, "wr1_r6");
    step(0, 0, 0, 0, 0, 0, 6, 4, "rd_r6");

    // Randomised traffic concentrated on a few registers to force collisions.
    prev_rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 59) == 0);
      we = !r && $urandom_range(0, 1) == 1;
      re = !prev_rst && $urandom_range(0, 2) != 0;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
      step(r, we, wa, $urandom(), re, ra, a1, a2, "random");
      prev_rst = r;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file with two combinational read ports and one write port.
- Adds write-through bypass and a per-register busy scoreboard for the pipelined core.
- Register 0 is optionally hardwired to zero.
- Sits in the decode stage: the issue logic reserves destination registers, writeback releases them, and hazard logic reads the busy flags.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, width of register address ports.
- NREG, 32, number of registers implemented (NREG <= 2**ADDR_W).
- ZERO_REG, 1, when 1 register 0 always reads 0, is never written and never becomes busy.
- BYPASS, 1, when 1 same-cycle write data is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_addr_1  in  ADDR_W  read port 1 address.
- read_addr_2  in  ADDR_W  read port 2 address.
- read_data_1  out  DATA_W  read port 1 data (combinational).
- read_data_2  out  DATA_W  read port 2 data (combinational).
- read_busy_1  out  1  register at read_addr_1 awaiting writeback.
- read_busy_2  out  1  register at read_addr_2 awaiting writeback.
- write_en  in  1  writeback strobe.
- write_addr  in  ADDR_W  writeback address.
- write_data  in  DATA_W  writeback data.
- rsv_en  in  1  issue-time reservation strobe.
- rsv_addr  in  ADDR_W  register to mark busy.
- busy_count  out  ADDR_W+1  number of registers currently busy (registered).

Behaviour:
- Reset:
  - Asynchronous on rst=1: every register cleared to 0, every busy bit cleared.
  - busy_count = 0 while rst is high and on the first edge after release.
  - Read data and busy outputs follow the cleared state combinationally.
- Write:
  - On posedge with write_en=1 and write_addr < NREG, the register takes write_data.
  - The write is ignored if write_addr=0 with ZERO_REG=1, or if write_addr >= NREG.
  - A valid write clears that register's busy bit.
- Reserve:
  - On posedge with rsv_en=1, rsv_addr < NREG and not (ZERO_REG and rsv_addr=0), that register's busy bit is set.
  - Reserving an already-busy register leaves it busy, with no count change.
- Simultaneous write and reserve:
  - Same address: data is written AND the busy bit ends set (reserve wins).
  - Different addresses: both take effect independently.
- busy_count:
  - Registered count of set busy bits, updated each edge by +1, -1 or 0 to match the bit changes.
  - Never wraps, since the maximum is NREG.
- Reads:
  - Combinational, zero latency.
  - Address >= NREG reads 0 with busy 0.
  - Address 0 with ZERO_REG=1 reads 0 with busy 0.
- Bypass (BYPASS=1):
  - Applies when write_en=1, write_addr equals the read address, and the write is valid per the rules above.
  - read_data = write_data and read_busy = 0 in that same cycle.
  - Both ports may bypass at once.
  - Reserve does not affect the current-cycle read_busy; it becomes visible after the edge.
- BYPASS=0: reads return the stored value, and new data is visible the cycle after the write edge.
- Reset mid-operation: any pending write, reserve or busy state is discarded immediately; no partial update survives.
- No X propagation: every register is defined after reset.

Test Plan:
- Reset, then read addresses 0..31 -> all read_data = 0, all busy = 0, busy_count = 0.
- Write 0xDEADBEEF to r5 with read_addr_1=5 in the same cycle -> read_data_1 = 0xDEADBEEF before the edge (bypass); after the edge a read of r5 with write_en=0 still gives 0xDEADBEEF.
- Write 0x12345678 to r0, and separately reserve r0 -> read_data_1 at addr 0 = 0, busy_1 = 0, busy_count = 0.
- Reserve r7, then r9, on two edges -> busy_count = 2, read_busy_1 at r7 = 1.
  - Write 0x55 to r7 -> in that cycle read_busy_1 = 0 and data 0x55; after the edge busy_count = 1.
- In one cycle: reserve r3 and write 0xAA to r3 -> after the edge r3 = 0xAA, busy = 1, busy_count incremented by 1.
- Reserve r4, write r6 = 0x77, then assert rst mid-cycle between edges -> immediately r4 busy = 0, r6 = 0, busy_count = 0; first post-reset write of 0x1 to r6 reads back 0x1.
